lcd_text_ctrl: RTL and testbench

LCD_TEXT_CTRL -- requirements
Module: lcd_text_ctrl

---
 rtl/lcd_text_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_lcd_text_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_ctrl.sv
// HD44780-style 8-bit text LCD controller: power-up wait, init sequence, then
// a character stream with cursor tracking, line wrap, LF/CR/FF/BS handling.
module lcd_text_ctrl #(
  parameter int unsigned COLS    = 16,
  parameter int unsigned ROWS    = 2,
  parameter int unsigned PWR_CYC = 2000000,
  parameter int unsigned E_CYC   = 24,
  parameter int unsigned CMD_CYC = 2400,
  parameter int unsigned CLR_CYC = 96000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_valid,
  input  logic [7:0] i_char,
  output logic       o_ready,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_e
);

  localparam int unsigned CntMax = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  // INIT spends one clock loading the first command, so PWR_WAIT ends one early.
  localparam logic [CntW-1:0] PwrLast = CntW'(PWR_CYC - 2);
  localparam logic [CntW-1:0] ELast   = CntW'(E_CYC);
  localparam logic [CntW-1:0] CmdLast = CntW'(CMD_CYC - 1);
  localparam logic [CntW-1:0] ClrLast = CntW'(CLR_CYC - 1);
  localparam logic [5:0]      ColLast = 6'(COLS - 1);

  localparam logic [2:0] PWR_WAIT = 3'd0;
  localparam logic [2:0] INIT     = 3'd1;
  localparam logic [2:0] IDLE     = 3'd2;
  localparam logic [2:0] BUS      = 3'd3;
  localparam logic [2:0] GAP      = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] gap_last_q, gap_last_d;
  logic            row_q, row_d;
  logic [5:0]      col_q, col_d;
  logic [2:0]      idx_q, idx_d;
  logic [2:0]      num_q, num_d;
  logic            init_q, init_d;
  logic [7:0]      data_q, data_d;
  logic            rs_q, rs_d;
  // Pending bus writes for the accepted character, {rs, data}.
  logic [8:0]      wr_q [4];
  logic [8:0]      wr_d [4];

  logic [8:0] dec_wr [4];
  logic [2:0] dec_num;
  logic       dec_row;
  logic [5:0] dec_col;
  logic       last_row;
  logic       printable;
  logic [5:0] col_dec;
  logic [2:0] idx_nx;
  logic [8:0] nxt_wr;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: init_cmd = 8'h38;
      3'd2:       init_cmd = 8'h0C;
      3'd3:       init_cmd = 8'h01;
      3'd4:       init_cmd = 8'h06;
      default:    init_cmd = 8'h00;
    endcase
  endfunction

  assign last_row  = (ROWS == 1) || row_q;
  assign printable = ((i_char >= 8'h20) && (i_char <= 8'h7E)) || (i_char >= 8'hA0);
  assign col_dec   = col_q - 6'd1;

  always_comb begin : decode
    dec_wr  = '{default: '0};
    dec_num = 3'd0;
    dec_row = row_q;
    dec_col = col_q;
    if (printable) begin
      dec_wr[0] = {1'b1, i_char};
      if (col_q == ColLast) begin
        dec_num   = 3'd2;
        dec_wr[1] = {1'b0, (last_row ? 8'h01 : 8'hC0)};
        dec_row   = ~last_row;
        dec_col   = 6'd0;
      end else begin
        dec_num = 3'd1;
        dec_col = col_q + 6'd1;
      end
    end else begin
      case (i_char)
        8'h0A: begin
          dec_num   = 3'd1;
          dec_wr[0] = {1'b0, (last_row ? 8'h01 : 8'hC0)};
          dec_row   = ~last_row;
          dec_col   = 6'd0;
        end
        8'h0D: begin
          dec_num   = 3'd1;
          dec_wr[0] = {1'b0, 1'b1, row_q, 6'd0};
          dec_col   = 6'd0;
        end
        8'h0C: begin
          dec_num   = 3'd1;
          dec_wr[0] = {1'b0, 8'h01};
          dec_row   = 1'b0;
          dec_col   = 6'd0;
        end
        8'h08: begin
          if (col_q != 6'd0) begin
            dec_num   = 3'd3;
            dec_wr[0] = {1'b0, 1'b1, row_q, col_dec};
            dec_wr[1] = {1'b1, 8'h20};
            dec_wr[2] = {1'b0, 1'b1, row_q, col_dec};
            dec_col   = col_dec;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin : next_state
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_last_d = gap_last_q;
    row_d      = row_q;
    col_d      = col_q;
    idx_d      = idx_q;
    num_d      = num_q;
    init_d     = init_q;
    data_d     = data_q;
    rs_d       = rs_q;
    wr_d       = wr_q;
    idx_nx     = idx_q + 3'd1;
    nxt_wr     = init_q ? {1'b0, init_cmd(idx_nx)} : wr_q[idx_nx[1:0]];
    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == PwrLast) begin
          state_d = INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      INIT: begin
        state_d = BUS;
        cnt_d   = '0;
        init_d  = 1'b1;
        idx_d   = 3'd0;
        num_d   = 3'd5;
        data_d  = init_cmd(3'd0);
        rs_d    = 1'b0;
      end
      IDLE: begin
        if (i_valid) begin
          wr_d   = dec_wr;
          num_d  = dec_num;
          row_d  = dec_row;
          col_d  = dec_col;
          idx_d  = 3'd0;
          init_d = 1'b0;
          cnt_d  = '0;
          if (dec_num != 3'd0) begin
            state_d = BUS;
            data_d  = dec_wr[0][7:0];
            rs_d    = dec_wr[0][8];
          end else begin
            // Dropped code: one GAP clock so ready reappears two cycles later.
            state_d    = GAP;
            gap_last_d = '0;
            data_d     = 8'h00;
            rs_d       = 1'b0;
          end
        end
      end
      BUS: begin
        if (cnt_q == ELast) begin
          state_d    = GAP;
          cnt_d      = '0;
          gap_last_d = (!rs_q && (data_q == 8'h01)) ? ClrLast : CmdLast;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      GAP: begin
        if (cnt_q == gap_last_q) begin
          cnt_d = '0;
          if (idx_nx < num_q) begin
            state_d = BUS;
            idx_d   = idx_nx;
            data_d  = nxt_wr[7:0];
            rs_d    = nxt_wr[8];
          end else begin
            state_d = IDLE;
            data_d  = 8'h00;
            rs_d    = 1'b0;
            init_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= PWR_WAIT;
      cnt_q      <= '0;
      gap_last_q <= '0;
      row_q      <= 1'b0;
      col_q      <= 6'd0;
      idx_q      <= 3'd0;
      num_q      <= 3'd0;
      init_q     <= 1'b0;
      data_q     <= 8'h00;
      rs_q       <= 1'b0;
      wr_q       <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_last_q <= gap_last_d;
      row_q      <= row_d;
      col_q      <= col_d;
      idx_q      <= idx_d;
      num_q      <= num_d;
      init_q     <= init_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
      wr_q       <= wr_d;
    end
  end

  assign o_ready    = (state_q == IDLE);
  assign o_lcd_e    = (state_q == BUS) && (cnt_q != '0);
  assign o_lcd_data = data_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Scoreboard bench for lcd_text_ctrl: a cursor model queues the expected bus
// writes; a monitor pops them on each E rise and checks timing and payload.
module tb_lcd_text_ctrl;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int PWR_CYC = 20;
  localparam int E_CYC = 2;
  localparam int CMD_CYC = 5;
  localparam int CLR_CYC = 10;
  localparam int W_CMD = 1 + E_CYC + CMD_CYC;
  localparam int W_CLR = 1 + E_CYC + CLR_CYC;
  localparam int INIT_READY = PWR_CYC + 4 * W_CMD + W_CLR;

  logic       clock;
  logic       reset;
  logic       i_valid;
  logic [7:0] i_char;
  logic       o_ready;
  logic [7:0] o_lcd_data;
  logic       o_lcd_rs;
  logic       o_lcd_rw;
  logic       o_lcd_e;

  lcd_text_ctrl #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .PWR_CYC(PWR_CYC),
    .E_CYC  (E_CYC),
    .CMD_CYC(CMD_CYC),
    .CLR_CYC(CLR_CYC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_char    (i_char),
    .o_ready   (o_ready),
    .o_lcd_data(o_lcd_data),
    .o_lcd_rs  (o_lcd_rs),
    .o_lcd_rw  (o_lcd_rw),
    .o_lcd_e   (o_lcd_e)
  );

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;  // expected clocks since previous E rise, 0 = unchecked
    int         at;   // expected clocks since reset release, 0 = unchecked
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errs = 0;
  int  cyc = 0;
  int  rel_cyc = 0;
  bit  in_rst = 1'b1;
  int  mrow = 0;
  int  mcol = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever @(posedge clock) cyc++;

  // Bus monitor
  initial begin
    logic       e_prev;
    int         e_len;
    int         last_rise;
    logic [8:0] held;
    wr_t        w;
    e_prev = 1'b0;
    e_len = 0;
    last_rise = 0;
    held = '0;
    forever begin
      @(negedge clock);
      if (o_lcd_e === 1'b1 && e_prev == 1'b0) begin
        check_eq("e_expected", (exp_q.size() > 0), 1);
        check_eq("rw", o_lcd_rw, 0);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check_eq("wr_rs", o_lcd_rs, w.rs);
          check_eq("wr_data", o_lcd_data, w.data);
          if (w.gap != 0) check_eq("rise_gap", cyc - last_rise, w.gap);
          if (w.at != 0) check_eq("rise_at", cyc - rel_cyc, w.at);
        end
        last_rise = cyc;
        held = {o_lcd_rs, o_lcd_data};
        e_len = 1;
      end else if (o_lcd_e === 1'b1) begin
        e_len++;
      end else if (e_prev == 1'b1 && !in_rst) begin
        check_eq("e_width", e_len, E_CYC);
        check_eq("hold", {o_lcd_rs, o_lcd_data}, held);
      end
      e_prev = (o_lcd_e === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_wr(input logic rs, input logic [7:0] data, input int gap, input int at);
    wr_t w;
    w.rs = rs;
    w.data = data;
    w.gap = gap;
    w.at = at;
    exp_q.push_back(w);
  endtask

  task automatic push_init();
    push_wr(1'b0, 8'h38, 0, PWR_CYC + 1);
    push_wr(1'b0, 8'h38, W_CMD, 0);
    push_wr(1'b0, 8'h0C, W_CMD, 0);
    push_wr(1'b0, 8'h01, W_CMD, 0);
    push_wr(1'b0, 8'h06, W_CLR, 0);
  endtask

  // Cursor model: queues the writes a character must produce, returns ready latency.
  task automatic model_char(input logic [7:0] c, output int lat);
    logic [8:0] seq[$];
    logic [7:0] a;
    int prev;
    if ((c >= 8'h20 && c <= 8'h7E) || c >= 8'hA0) begin
      seq.push_back({1'b1, c});
      mcol++;
      if (mcol == COLS) begin
        if (mrow < ROWS - 1) begin
          seq.push_back({1'b0, 8'hC0});
          mrow = mrow + 1;
        end else begin
          seq.push_back({1'b0, 8'h01});
          mrow = 0;
        end
        mcol = 0;
      end
    end else if (c == 8'h0A) begin
      if (mrow < ROWS - 1) begin
        seq.push_back({1'b0, 8'hC0});
        mrow = mrow + 1;
      end else begin
        seq.push_back({1'b0, 8'h01});
        mrow = 0;
      end
      mcol = 0;
    end else if (c == 8'h0D) begin
      seq.push_back({1'b0, (mrow != 0) ? 8'hC0 : 8'h80});
      mcol = 0;
    end else if (c == 8'h0C) begin
      seq.push_back({1'b0, 8'h01});
      mrow = 0;
      mcol = 0;
    end else if (c == 8'h08 && mcol > 0) begin
      a = 8'h80 + ((mrow != 0) ? 8'h40 : 8'h00) + 8'(mcol - 1);
      seq.push_back({1'b0, a});
      seq.push_back({1'b1, 8'h20});
      seq.push_back({1'b0, a});
      mcol = mcol - 1;
    end
    if (seq.size() == 0) begin
      lat = 2;
    end else begin
      lat = 1;
      prev = 0;
      foreach (seq[i]) begin
        push_wr(seq[i][8], seq[i][7:0], prev, 0);
        prev = (seq[i] == 9'h001) ? W_CLR : W_CMD;
        lat += prev;
      end
    end
  endtask

  task automatic accept_char(input logic [7:0] c, output int lat);
    int k;
    k = 0;
    @(negedge clock);
    while (o_ready !== 1'b1 && k < 500) begin
      @(negedge clock);
      k++;
    end
    check_eq("ready_wait", o_ready, 1);
    check_eq("idle_data", o_lcd_data, 8'h00);
    i_valid = 1'b1;
    i_char = c;
    model_char(c, lat);
    @(posedge clock);
    #1;
    i_valid = 1'b0;
    i_char = 8'($urandom);
  endtask

  task automatic send_char(input logic [7:0] c);
    int lat;
    int n;
    accept_char(c, lat);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (o_ready !== 1'b1 && n < 500);
    check_eq($sformatf("ready_lat_%02h", c), n, lat);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, o_ready, 0);
    check_eq({tag, "_e"}, o_lcd_e, 0);
    check_eq({tag, "_data"}, o_lcd_data, 8'h00);
    check_eq({tag, "_rs"}, o_lcd_rs, 0);
    check_eq({tag, "_rw"}, o_lcd_rw, 0);
  endtask

  task automatic release_and_init();
    int k;
    @(negedge clock);
    push_init();
    mrow = 0;
    mcol = 0;
    reset = 1'b0;
    in_rst = 1'b0;
    rel_cyc = cyc;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (o_ready !== 1'b1 && k < 1000);
    check_eq("init_ready_at", cyc - rel_cyc, INIT_READY);
    check_eq("init_drained", exp_q.size(), 0);
  endtask

  initial begin
    int lat;
    int k;
    reset = 1'b1;
    i_valid = 1'b0;
    i_char = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("por");
    release_and_init();

    send_char(8'h41);        // 'A' -> (0,1)
    send_char(8'h0C);        // FF -> clear, (0,0)
    send_str("ABCD");        // wrap to row 1 via 0xC0
    send_str("EFGH");        // wrap past last row via 0x01
    send_str("ABC");         // (0,3)
    send_char(8'h08);        // 0x82, 0x20, 0x82 -> (0,2)
    send_char(8'h0D);        // 0x80 -> (0,0)
    send_char(8'h08);        // nothing to erase
    send_char(8'h0A);        // 0xC0 -> (1,0)
    send_str("XYZ");         // (1,3)
    send_char(8'h0D);        // 0xC0 -> (1,0)
    send_char(8'h07);
    send_char(8'h7F);
    send_char(8'h90);
    send_char(8'hA5);        // high printable -> (1,1)
    send_char(8'h0A);        // LF on last row -> 0x01
    check_eq("sb_drained", exp_q.size(), 0);

    // Reset in the middle of an E pulse
    accept_char(8'h51, lat);
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (o_lcd_e !== 1'b1 && k < 50);
    check_eq("e_seen", o_lcd_e, 1);
    in_rst = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_reset_outputs("mid_e");
    exp_q.delete();
    repeat (2) @(posedge clock);
    release_and_init();
    send_char(8'h5A);
    check_eq("final_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
